// File: rtl/mdu_seq_pkg.sv
// rtl/mdu_seq_pkg.sv - shared types, opcodes and helpers for the multiply/divide sequencer
package mdu_seq_pkg;

    localparam int CPU_WIDTH     = 64;
    localparam int EXU_OPT_WIDTH = 5;

    localparam logic [EXU_OPT_WIDTH-1:0] ALU_ADD    = 5'd0;
    localparam logic [EXU_OPT_WIDTH-1:0] ALU_SUB    = 5'd1;
    localparam logic [EXU_OPT_WIDTH-1:0] ALU_AND    = 5'd2;
    localparam logic [EXU_OPT_WIDTH-1:0] ALU_OR     = 5'd3;
    localparam logic [EXU_OPT_WIDTH-1:0] ALU_XOR    = 5'd4;
    localparam logic [EXU_OPT_WIDTH-1:0] ALU_MUL    = 5'd16;
    localparam logic [EXU_OPT_WIDTH-1:0] ALU_MULH   = 5'd17;
    localparam logic [EXU_OPT_WIDTH-1:0] ALU_MULHSU = 5'd18;
    localparam logic [EXU_OPT_WIDTH-1:0] ALU_MULHU  = 5'd19;
    localparam logic [EXU_OPT_WIDTH-1:0] ALU_DIV    = 5'd20;
    localparam logic [EXU_OPT_WIDTH-1:0] ALU_DIVU   = 5'd21;
    localparam logic [EXU_OPT_WIDTH-1:0] ALU_REM    = 5'd22;
    localparam logic [EXU_OPT_WIDTH-1:0] ALU_REMU   = 5'd23;
    localparam logic [EXU_OPT_WIDTH-1:0] ALU_MULW   = 5'd24;
    localparam logic [EXU_OPT_WIDTH-1:0] ALU_DIVW   = 5'd25;
    localparam logic [EXU_OPT_WIDTH-1:0] ALU_DIVUW  = 5'd26;
    localparam logic [EXU_OPT_WIDTH-1:0] ALU_REMW   = 5'd27;
    localparam logic [EXU_OPT_WIDTH-1:0] ALU_REMUW  = 5'd28;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } mdu_state_e;

    typedef struct packed {
        logic is_div;
        logic is_rem;
        logic hi;
        logic word;
        logic s1_signed;
        logic s2_signed;
        logic legal;
    } mdu_op_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/mdu_opdec.sv
// rtl/mdu_opdec.sv - combinational opcode decoder for the multiply/divide sequencer
module mdu_opdec
    import mdu_seq_pkg::*;
(
    input  logic [EXU_OPT_WIDTH-1:0] i_opt,
    output mdu_op_t                  o_op
);

    always_comb begin
        o_op       = '0;
        o_op.legal = 1'b1;
        case (i_opt)
            ALU_MUL:    begin o_op.s1_signed = 1'b1; o_op.s2_signed = 1'b1; end
            ALU_MULH:   begin o_op.hi = 1'b1; o_op.s1_signed = 1'b1; o_op.s2_signed = 1'b1; end
            ALU_MULHSU: begin o_op.hi = 1'b1; o_op.s1_signed = 1'b1; end
            ALU_MULHU:  o_op.hi = 1'b1;
            ALU_MULW:   begin o_op.word = 1'b1; o_op.s1_signed = 1'b1; o_op.s2_signed = 1'b1; end
            ALU_DIV:    begin o_op.is_div = 1'b1; o_op.s1_signed = 1'b1; o_op.s2_signed = 1'b1; end
            ALU_DIVU:   o_op.is_div = 1'b1;
            ALU_REM:    begin o_op.is_div = 1'b1; o_op.is_rem = 1'b1; o_op.s1_signed = 1'b1; o_op.s2_signed = 1'b1; end
            ALU_REMU:   begin o_op.is_div = 1'b1; o_op.is_rem = 1'b1; end
            ALU_DIVW:   begin o_op.is_div = 1'b1; o_op.word = 1'b1; o_op.s1_signed = 1'b1; o_op.s2_signed = 1'b1; end
            ALU_DIVUW:  begin o_op.is_div = 1'b1; o_op.word = 1'b1; end
            ALU_REMW:   begin o_op.is_div = 1'b1; o_op.is_rem = 1'b1; o_op.word = 1'b1; o_op.s1_signed = 1'b1; o_op.s2_signed = 1'b1; end
            ALU_REMUW:  begin o_op.is_div = 1'b1; o_op.is_rem = 1'b1; o_op.word = 1'b1; end
            default:    o_op.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative RV64M multiply/divide sequencer with valid/ready handshake
module mdu_seq
    import mdu_seq_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [EXU_OPT_WIDTH-1:0] i_opt,
    input  logic [CPU_WIDTH-1:0]     i_src1,
    input  logic [CPU_WIDTH-1:0]     i_src2,
    input  logic                     i_flush,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [CPU_WIDTH-1:0]     o_res,
    output logic                     o_busy
);

    mdu_state_e     state, state_nxt;
    mdu_op_t        dec;
    logic [5:0]     cnt;
    logic           op_div, op_rem, op_hi, op_word;
    logic           neg1, neg2;
    logic [63:0]    mcand;
    logic [127:0]   prod;
    logic [64:0]    rem;
    logic [63:0]    quo;

    logic           accept, special, div_zero, div_ovf, a_neg, b_neg;
    logic [63:0]    a_ext, b_ext, a_abs, b_abs, spec_res;
    logic [64:0]    mul_acc;
    logic [65:0]    dsub;
    logic [127:0]   p_mag, p_fix;
    logic [63:0]    q_fix, r_fix, res_sel, fix_res;

    mdu_opdec u_opdec (
        .i_opt (i_opt),
        .o_op  (dec)
    );

    assign o_ready = (state == IDLE) & ~i_rst;
    assign o_busy  = (state != IDLE);
    assign accept  = i_valid & o_ready & ~i_flush;

    assign a_ext = !dec.word ? i_src1 :
                   dec.s1_signed ? sext32(i_src1[31:0]) : {32'd0, i_src1[31:0]};
    assign b_ext = !dec.word ? i_src2 :
                   dec.s2_signed ? sext32(i_src2[31:0]) : {32'd0, i_src2[31:0]};
    assign a_neg = dec.s1_signed & a_ext[63];
    assign b_neg = dec.s2_signed & b_ext[63];
    assign a_abs = a_neg ? (64'd0 - a_ext) : a_ext;
    assign b_abs = b_neg ? (64'd0 - b_ext) : b_ext;

    // Word operands are already sign-extended, so one 64-bit compare covers both widths.
    assign div_zero = dec.is_div & (b_ext == 64'd0);
    assign div_ovf  = dec.is_div & dec.s1_signed & (b_ext == {64{1'b1}}) &
                      (a_ext == (dec.word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    assign special  = ~dec.legal | div_zero | div_ovf;

    always_comb begin
        spec_res = '0;
        if (div_zero)
            spec_res = dec.is_rem ? a_ext : {64{1'b1}};
        else if (div_ovf)
            spec_res = dec.is_rem ? 64'd0 : a_ext;
        if (dec.word)
            spec_res = sext32(spec_res[31:0]);
    end

    assign mul_acc = prod[0] ? ({1'b0, prod[127:64]} + {1'b0, mcand}) : {1'b0, prod[127:64]};
    assign dsub    = {rem, quo[63]} - {2'b00, mcand};

    // After 32 iterations the word product sits 32 bits higher than a full-width one.
    assign p_mag   = op_word ? {32'd0, prod[127:32]} : prod;
    assign p_fix   = (neg1 ^ neg2) ? (128'd0 - p_mag) : p_mag;
    assign q_fix   = (neg1 ^ neg2) ? (64'd0 - quo) : quo;
    assign r_fix   = neg1 ? (64'd0 - rem[63:0]) : rem[63:0];
    assign res_sel = op_div ? (op_rem ? r_fix : q_fix) : (op_hi ? p_fix[127:64] : p_fix[63:0]);
    assign fix_res = op_word ? sext32(res_sel[31:0]) : res_sel;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : (dec.is_div ? DIV : MUL);
            MUL,
            DIV:  if (cnt == 6'd0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (i_flush)
            state_nxt = IDLE;
    end

    always_ff @(posedge i_clk) begin
        case (state)
            IDLE: if (accept) begin
                op_div  <= dec.is_div;
                op_rem  <= dec.is_rem;
                op_hi   <= dec.hi;
                op_word <= dec.word;
                neg1    <= a_neg;
                neg2    <= b_neg;
                cnt     <= dec.word ? 6'd31 : 6'd63;
                mcand   <= dec.is_div ? b_abs : a_abs;
                prod    <= {64'd0, b_abs};
                quo     <= dec.word ? {a_abs[31:0], 32'd0} : a_abs;
                rem     <= '0;
            end
            MUL: begin
                prod <= {mul_acc, prod[63:1]};
                cnt  <= cnt - 6'd1;
            end
            DIV: begin
                rem <= dsub[65] ? {rem[63:0], quo[63]} : dsub[64:0];
                quo <= {quo[62:0], ~dsub[65]};
                cnt <= cnt - 6'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            o_valid <= 1'b0;
            o_res   <= '0;
        end else begin
            case (state)
                IDLE: if (accept && special) begin
                    o_res   <= spec_res;
                    o_valid <= 1'b1;
                end
                FIX: begin
                    o_res   <= fix_res;
                    o_valid <= 1'b1;
                end
                DONE: if (i_ready) o_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking bench for the multiply/divide sequencer
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [4:0]  i_opt;
    logic [63:0] i_src1;
    logic [63:0] i_src2;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [63:0] o_res;
    logic        o_busy;

    mdu_seq dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_opt   (i_opt),
        .i_src1  (i_src1),
        .i_src2  (i_src2),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_res   (o_res),
        .o_busy  (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int delivered = 0;
    bit seen      = 0;
    logic [63:0] held;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc;
    } exp_t;
    exp_t q[$];
    exp_t e;

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] mdl(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  aw, bw, t;
        logic         ovf64, ovf32;
        aw    = a[31:0];
        bw    = b[31:0];
        ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        ovf32 = (aw == 32'h8000_0000) && (bw == 32'hFFFF_FFFF);
        case (op)
            ALU_MUL:    return a * b;
            ALU_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            ALU_MULHSU: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
            ALU_MULHU:  begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
            ALU_MULW:   begin t = aw * bw; return sx(t); end
            ALU_DIV:    if (b == 0) return '1; else if (ovf64) return a; else return $signed(a) / $signed(b);
            ALU_DIVU:   if (b == 0) return '1; else return a / b;
            ALU_REM:    if (b == 0) return a; else if (ovf64) return 64'd0; else return $signed(a) % $signed(b);
            ALU_REMU:   if (b == 0) return a; else return a % b;
            ALU_DIVW:   begin
                if (bw == 0) return '1;
                if (ovf32) return sx(aw);
                t = $signed(aw) / $signed(bw); return sx(t);
            end
            ALU_DIVUW:  begin if (bw == 0) return '1; t = aw / bw; return sx(t); end
            ALU_REMW:   begin
                if (bw == 0) return sx(aw);
                if (ovf32) return 64'd0;
                t = $signed(aw) % $signed(bw); return sx(t);
            end
            ALU_REMUW:  begin if (bw == 0) return sx(aw); t = aw % bw; return sx(t); end
            default:    return 64'd0;
        endcase
    endfunction

    function automatic int mdl_lat(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: return 66;
            ALU_MULW:            return 34;
            ALU_DIV, ALU_REM:    return (b == 0 || (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)) ? 1 : 66;
            ALU_DIVU, ALU_REMU:  return (b == 0) ? 1 : 66;
            ALU_DIVW, ALU_REMW:  return (b[31:0] == 0 || (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)) ? 1 : 34;
            ALU_DIVUW, ALU_REMUW: return (b[31:0] == 0) ? 1 : 34;
            default:             return 1;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && o_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid actual=1 required=0 res=%h", o_res);
            end else if (!seen) begin
                e = q[0];
                chk("model_res", o_res, e.res);
                chk("model_lat", 64'(cyc - e.acc), 64'(e.lat));
                seen = 1;
                held = o_res;
            end else begin
                chk("res_stable", o_res, held);
            end
            chk("ready_low_in_done", {63'd0, o_ready}, 64'd0);
        end
        if (rst || i_flush) begin
            q.delete();
            seen = 0;
        end else begin
            if (o_valid && i_ready && q.size() > 0) begin
                void'(q.pop_front());
                seen = 0;
                delivered++;
            end
            if (i_valid && o_ready) begin
                e.res = mdl(i_opt, i_src1, i_src2);
                e.lat = mdl_lat(i_opt, i_src1, i_src2);
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic wait_ready(input string nm);
        int t;
        t = 0;
        while (!o_ready && t < 100) begin @(posedge clk); #1; t++; end
        chk({nm, "_ready"}, {63'd0, o_ready}, 64'd1);
    endtask

    task automatic issue(input logic [4:0] opt, input logic [63:0] a, input logic [63:0] b);
        i_valid = 1'b1; i_opt = opt; i_src1 = a; i_src2 = b;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic do_op(input string nm, input logic [4:0] opt, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] lit, input int lat, input int hold);
        int t;
        wait_ready(nm);
        issue(opt, a, b);
        t = 0;
        while (!o_valid && t < 200) begin @(posedge clk); #1; t++; end
        chk({nm, "_lat"}, 64'(t + 1), 64'(lat));
        if (o_valid) begin
            chk({nm, "_res"}, o_res, lit);
            repeat (hold) begin @(posedge clk); #1; end
            i_ready = 1'b1;
            @(posedge clk); #1;
            i_ready = 1'b0;
            chk({nm, "_idle"}, {62'd0, o_valid, o_ready}, 64'd1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int d0;
        bit vseen;
        rst = 1'b1; i_valid = 1'b0; i_opt = '0; i_src1 = '0; i_src2 = '0; i_flush = 1'b0; i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_res",   o_res, 64'd0);
        chk("rst_busy",  {63'd0, o_busy}, 64'd0);
        chk("rst_ready", {63'd0, o_ready}, 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {63'd0, o_ready}, 64'd1);

        do_op("mul",     ALU_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, 0);
        do_op("mulhu",   ALU_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
        do_op("mulh",    ALU_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66, 0);
        do_op("mulhsu",  ALU_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
        do_op("divw",    ALU_DIVW,   64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 34, 0);
        do_op("remw",    ALU_REMW,   64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
        do_op("divuw",   ALU_DIVUW,  64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 34, 0);
        do_op("div0",    ALU_DIV,    64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        do_op("rem0",    ALU_REM,    64'd7, 64'd0, 64'd7, 1, 0);
        do_op("divovf",  ALU_DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 0);
        do_op("removf",  ALU_REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
        do_op("divneg",  ALU_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
        do_op("remu",    ALU_REMU,   64'd100, 64'd7, 64'd2, 66, 2);
        do_op("mulw",    ALU_MULW,   64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0);
        do_op("divwovf", ALU_DIVW,   64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
        do_op("remuw0",  ALU_REMUW,  64'd5, 64'hFFFF_FFFF_0000_0000, 64'd5, 1, 0);
        do_op("illegal", ALU_ADD,    64'd3, 64'd4, 64'd0, 1, 0);
        do_op("bp",      ALU_MULHU,  64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 66, 5);

        // flush in the middle of a divide
        wait_ready("flush");
        issue(ALU_DIV, 64'd100, 64'd7);
        repeat (9) @(posedge clk);
        #1;
        chk("flush_busy_before", {63'd0, o_busy}, 64'd1);
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        chk("flush_valid", {63'd0, o_valid}, 64'd0);
        chk("flush_ready", {63'd0, o_ready}, 64'd1);
        vseen = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (o_valid) vseen = 1;
        end
        chk("flush_no_valid", {63'd0, vseen}, 64'd0);
        do_op("mul_after_flush", ALU_MUL, 64'd3, 64'd5, 64'd15, 66, 0);

        // flush wins over a handshake in DONE
        wait_ready("flushdone");
        issue(ALU_DIV, 64'd7, 64'd0);
        chk("flushdone_valid", {63'd0, o_valid}, 64'd1);
        d0 = delivered;
        i_ready = 1'b1; i_flush = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0; i_flush = 1'b0;
        chk("flushdone_cleared", {63'd0, o_valid}, 64'd0);
        chk("flushdone_ready", {63'd0, o_ready}, 64'd1);
        chk("flushdone_not_delivered", 64'(delivered), 64'(d0));

        // reset in the middle of a multiply
        wait_ready("rstmul");
        issue(ALU_MUL, 64'h1234, 64'h5678);
        repeat (20) @(posedge clk);
        #1;
        chk("rstmul_busy_before", {63'd0, o_busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmul_valid", {63'd0, o_valid}, 64'd0);
        chk("rstmul_res",   o_res, 64'd0);
        chk("rstmul_busy",  {63'd0, o_busy}, 64'd0);
        chk("rstmul_ready_in_rst", {63'd0, o_ready}, 64'd0);
        rst = 1'b0;
        #1;
        chk("rstmul_ready_after", {63'd0, o_ready}, 64'd1);
        do_op("mul_after_rst", ALU_MUL, 64'h1234, 64'h5678, 64'h0626_0060, 66, 0);

        t = 0;
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
